nfifo_rr_drain: RTL
===================

// Module: nfifo_rr_drain
// PURPOSE
//  Round-robin scheduler that drains N router input FIFOs onto one output link.
//  Picks an eligible FIFO, pulses its read, and registers the head word onto a valid/ready output.
//  Optionally holds the grant for a whole packet (wormhole lock).
//  Sits between a router port's per-VC/per-input FIFOs and the crossbar/link stage.
// PARAMETERS
//  N         4   number of FIFOs served (>=2)
//  width     32  data word width
//  LOCK_PKT  0   1: hold grant until a tail word is taken; 0: re-arbitrate every word
//  TAIL_BIT  31  bit index of the tail flag in the data word (used only if LOCK_PKT=1)
// PORTS
//  clk_i         in   1            clock, all logic on posedge
//  rst_i         in   1            reset, synchronous, active-high
//  fifo_empty_i  in   N            per-FIFO empty flag, registered by the FIFO
//  fifo_data_i   in   N*width      per-FIFO head word, slice k = [k*width +: width]
//  fifo_read_o   out  N            one-hot pop strobe, at most one bit set per cycle
//  out_valid_o   out  1            output word valid
//  out_ready_i   in   1            downstream accepts when valid&ready at posedge
//  out_data_o    out  width        output word
//  out_src_o     out  $clog2(N)    index of the FIFO the output word came from
//  locked_o      out  1            packet lock active (always 0 when LOCK_PKT=0)
// BEHAVIOUR
//  - Reset (rst_i high at posedge): fifo_read_o=0, out_valid_o=0, out_data_o=0, out_src_o=0,
//    locked_o=0, rr pointer=0, cooldown mask=0. Reset mid-transfer drops the held word; nothing is replayed.
//  - FIFO timing: a pop at posedge t updates the FIFO's empty/data at posedge t+1.
//    The popped FIFO is therefore ineligible for the one cycle after its read (cooldown).
//    Max rate from one FIFO is 1 word per 2 cycles.
//  - Eligible[k] = ~fifo_empty_i[k] & ~cooldown[k] & (~locked | k==lock_idx).
//  - Slot free = ~out_valid_o | out_ready_i.
//  - Issue cycle: if slot free and any eligible, winner w = first eligible at or after the rr pointer (wrapping).
//    Combinationally fifo_read_o[w]=1. At posedge: out_data_o<=fifo_data_i[w], out_src_o<=w,
//    out_valid_o<=1, cooldown<=onehot(w), rr pointer<=(w+1)%N.
//  - Latency: word present at head -> out_valid_o one cycle after read strobe.
//    Back-to-back words from different FIFOs give 1 word/cycle.
//  - No issue: if the slot is free and nothing is eligible, out_valid_o<=0 once consumed.
//    If the slot is not free, the output holds stable and fifo_read_o=0.
//  - fifo_read_o never asserts for an empty FIFO or while the output register is stalled.
//  - LOCK_PKT=1, FSM ARB/LOCK:
//    ARB: on issue of a word with data[TAIL_BIT]=0 -> LOCK, lock_idx<=w, locked_o<=1.
//    LOCK: only lock_idx is eligible; other FIFOs wait even if lock_idx is empty or in cooldown.
//    LOCK: on issue of a word with data[TAIL_BIT]=1 -> ARB, locked_o<=0.
//    rr pointer advances only on the exit from LOCK or on a single-word packet.
//  - Simultaneous valid&ready consume and new issue in one cycle is required (no bubble).
//  - N not a power of 2: pointer wraps at N-1 -> 0 explicitly; no out-of-range index.
// STRUCTURE
//  - Package nfifo_arb_pkg: arb_state_t enum {ARB, LOCK}; function onehot_to_idx;
//    function rr_pick(req, ptr) for the wrapping first-set search.
//  - One sub-module rr_pick_n: combinational rotating-priority picker, N-bit req + pointer
//    -> one-hot grant + index, any_o.
//  - Top holds the output register, cooldown mask, rr pointer and lock FSM.
// TESTING
//  - Reset: assert rst_i 2 cycles with all FIFOs non-empty -> all outputs 0, no read strobe.
//    First read after release goes to FIFO 0.
//  - Fairness: N=4, all FIFOs non-empty, ready=1 -> read order 0,1,2,3,0 with out_valid_o high every cycle.
//    out_src_o sequence matches.
//  - Cooldown: only FIFO 2 non-empty with 4 words, ready=1 -> reads on alternate cycles; 4 words out in 8 cycles.
//  - Backpressure: ready=0 for 5 cycles mid-stream -> out_data_o/out_src_o stable, fifo_read_o=0.
//    Stream resumes with no loss or duplicate.
//  - Packet lock (LOCK_PKT=1): FIFO 1 holds 3 words (tail on 3rd), FIFO 0 and FIFO 3 busy.
//    -> three words from FIFO 1 contiguous, locked_o high until the tail issues, next grant goes to FIFO 2/3 per pointer.
//  - Mid-transfer reset: pulse rst_i while out_valid_o=1 and locked_o=1 -> next cycle valid=0, locked_o=0, pointer=0.

Source files
------------

// File: rtl/nfifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// nfifo_arb_pkg
// Shared types and helpers for the round-robin FIFO drain scheduler.
//   arb_state_t   : packet-lock FSM states (ARB / LOCK)
//   pick_t        : result of a rotating-priority search (any + index)
//   onehot_to_idx : one-hot vector -> binary index
//   rr_pick       : first set request at or after a pointer, wrapping at n-1
// Helpers work on MAX_N-wide vectors; callers zero-extend narrower requests.
// ---------------------------------------------------------------------------
package nfifo_arb_pkg;

    localparam int unsigned MAX_N = 32'd32;
    localparam int unsigned IDX_W = 32'd5;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             any;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int k = 0; k < int'(MAX_N); k++) begin
            idx = idx | (IDX_W'(k) & {IDX_W{oh[k]}});
        end
        return idx;
    endfunction

    // Only the first n request bits take part; the index wraps n-1 -> 0
    // explicitly so a non-power-of-two n never produces an out-of-range pick.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input logic [IDX_W-1:0] ptr,
                                      input int unsigned      n);
        pick_t       res;
        int unsigned j;
        res = '{any: 1'b0, idx: {IDX_W{1'b0}}};
        for (int unsigned i = 32'd0; i < MAX_N; i++) begin
            if (i < n) begin
                j = 32'(ptr) + i;
                if (j >= n) begin
                    j = j - n;
                end else begin
                    j = j;
                end
                if (!res.any && req[j[IDX_W-1:0]]) begin
                    res.any = 1'b1;
                    res.idx = j[IDX_W-1:0];
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// ---------------------------------------------------------------------------
// rr_pick_n
// Combinational rotating-priority picker.
//   req_i [N]   : request vector
//   ptr_i [IW]  : highest-priority position this cycle
//   gnt_o [N]   : one-hot grant (zero when no request)
//   idx_o [IW]  : binary index of the grant
//   any_o       : at least one request present
// ---------------------------------------------------------------------------
module rr_pick_n
    import nfifo_arb_pkg::*;
#(
    parameter  int unsigned N  = 32'd4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    pick_t            pick_s;
    logic [IDX_W-1:0] idx_full_s;
    logic             unused_idx_s;

    assign pick_s = rr_pick(MAX_N'(req_i), IDX_W'(ptr_i), N);

    // Expand the winning index into a one-hot grant.
    always_comb begin
        gnt_o = {N{1'b0}};
        for (int k = 0; k < int'(N); k++) begin
            gnt_o[k] = pick_s.any & (pick_s.idx == IDX_W'(k));
        end
    end

    assign idx_full_s   = onehot_to_idx(MAX_N'(gnt_o));
    assign idx_o        = idx_full_s[IW-1:0];
    assign any_o        = pick_s.any;
    // Upper index bits are always zero for N below MAX_N.
    assign unused_idx_s = ^idx_full_s;

endmodule

// File: rtl/nfifo_rr_drain.sv
// ---------------------------------------------------------------------------
// nfifo_rr_drain
// Round-robin drain of N router input FIFOs onto one valid/ready link, with
// optional wormhole lock that holds the grant until a tail word is issued.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   fifo_empty_i [N]    : per-FIFO empty flag
//   fifo_data_i [N*W]   : per-FIFO head word, slice k = [k*width +: width]
//   fifo_read_o [N]     : one-hot pop strobe (combinational)
//   out_valid_o/ready_i : output handshake
//   out_data_o, out_src_o : registered output word and its source FIFO
//   locked_o            : packet lock active
// A popped FIFO only shows its next head one cycle later, so it is masked
// (cooldown) for the cycle right after its read.
// ---------------------------------------------------------------------------
module nfifo_rr_drain
    import nfifo_arb_pkg::*;
#(
    parameter  int unsigned N        = 32'd4,
    parameter  int unsigned width    = 32'd32,
    parameter  int unsigned LOCK_PKT = 32'd0,
    parameter  int unsigned TAIL_BIT = 32'd31,
    localparam int unsigned IW       = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         fifo_empty_i,
    input  logic [N*width-1:0]   fifo_data_i,
    output logic [N-1:0]         fifo_read_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [width-1:0]     out_data_o,
    output logic [IW-1:0]        out_src_o,
    output logic                 locked_o
);

    logic [N-1:0]     elig_s, gnt_s, cool_q, cool_d;
    logic [IW-1:0]    win_s, nxt_ptr_s, ptr_q, ptr_d, lock_idx_q;
    logic [IW-1:0]    out_src_q, out_src_d;
    logic [width-1:0] win_data_s, out_data_q, out_data_d;
    logic             any_s, slot_free_s, issue_s, tail_s, advance_s;
    logic             out_valid_q, out_valid_d, locked_q;
    arb_state_t       state_q;

    // Eligibility: non-empty, not just popped, and the locked FIFO when locked.
    always_comb begin
        elig_s = {N{1'b0}};
        for (int k = 0; k < int'(N); k++) begin
            elig_s[k] = ~fifo_empty_i[k] & ~cool_q[k] &
                        (~locked_q | (lock_idx_q == IW'(k)));
        end
    end

    rr_pick_n #(.N(N)) u_pick (
        .req_i (elig_s),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s),
        .idx_o (win_s),
        .any_o (any_s)
    );

    // AND-OR mux of the winning FIFO's head word.
    always_comb begin
        win_data_s = {width{1'b0}};
        for (int k = 0; k < int'(N); k++) begin
            win_data_s = win_data_s | (fifo_data_i[k*width +: width] & {width{gnt_s[k]}});
        end
    end

    // Slot frees in the same cycle the held word is consumed, so no bubble.
    assign slot_free_s = ~out_valid_q | out_ready_i;
    assign issue_s     = slot_free_s & any_s & ~rst_i;
    assign fifo_read_o = gnt_s & {N{issue_s}};
    assign tail_s      = win_data_s[TAIL_BIT];
    assign nxt_ptr_s   = (win_s == IW'(N - 32'd1)) ? {IW{1'b0}} : (win_s + IW'(32'd1));
    // Inside a locked packet the pointer stays put until the tail goes out.
    assign advance_s   = (LOCK_PKT == 32'd0) || tail_s;

    // Next-state for output register, cooldown mask and rr pointer.
    always_comb begin
        cool_d      = {N{1'b0}};
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (issue_s) begin
            cool_d      = gnt_s;
            out_valid_d = 1'b1;
            out_data_d  = win_data_s;
            out_src_d   = win_s;
            if (advance_s) begin
                ptr_d = nxt_ptr_s;
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cool_q      <= {N{1'b0}};
            ptr_q       <= {IW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {width{1'b0}};
            out_src_q   <= {IW{1'b0}};
        end else begin
            cool_q      <= cool_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    // Packet-lock FSM: a non-tail word locks onto its FIFO, a tail releases.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB;
            locked_q   <= 1'b0;
            lock_idx_q <= {IW{1'b0}};
        end else if ((LOCK_PKT != 32'd0) && issue_s) begin
            case (state_q)
                ARB: begin
                    if (!tail_s) begin
                        state_q    <= LOCK;
                        locked_q   <= 1'b1;
                        lock_idx_q <= win_s;
                    end else begin
                        state_q    <= ARB;
                        locked_q   <= 1'b0;
                    end
                end
                LOCK: begin
                    if (tail_s) begin
                        state_q  <= ARB;
                        locked_q <= 1'b0;
                    end else begin
                        state_q  <= LOCK;
                        locked_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ARB;
                    locked_q <= 1'b0;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign locked_o    = locked_q;

endmodule
